// File: rtl/z_decoder.sv
// z_decoder: single-cycle-latency instruction decoder for a small MIPS-like core.
// The opcode and shift field are decoded combinationally, and the result is
// captured in output registers. There is no other state.
module z_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins_in,
  output logic        jump,
  output logic        branch,
  output logic        mem_to_reg,
  output logic        sign_ext,
  output logic        reg_dest,
  output logic        mem_write,
  output logic        alu_sel,
  output logic        reg_write,
  output logic [5:0]  shamt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [5:0] w_opcode;
  logic       w_jump;
  logic       w_branch;
  logic       w_mem_to_reg;
  logic       w_sign_ext;
  logic       w_reg_dest;
  logic       w_mem_write;
  logic       w_alu_sel;
  logic       w_reg_write;
  logic [5:0] w_shamt;

  logic       r_jump;
  logic       r_branch;
  logic       r_mem_to_reg;
  logic       r_sign_ext;
  logic       r_reg_dest;
  logic       r_mem_write;
  logic       r_alu_sel;
  logic       r_reg_write;
  logic [5:0] r_shamt;

  assign w_opcode = ins_in[31:26];

  // Combinational opcode decode; unknown opcodes fall through as a NOP (all zero).
  always_comb begin
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_sign_ext   = 1'b0;
    w_reg_dest   = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_sel    = 1'b0;
    w_reg_write  = 1'b0;
    w_shamt      = 6'd0;
    case (w_opcode)
      OP_RTYPE: begin
        w_reg_dest  = 1'b1;
        w_reg_write = 1'b1;
        w_shamt     = {1'b0, ins_in[10:6]};
      end
      OP_J: begin
        w_jump = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_branch   = 1'b1;
        w_sign_ext = 1'b1;
      end
      OP_ADDI: begin
        w_reg_write = 1'b1;
        w_alu_sel   = 1'b1;
        w_sign_ext  = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        w_reg_write = 1'b1;
        w_alu_sel   = 1'b1;
      end
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_sel    = 1'b1;
        w_sign_ext   = 1'b1;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_sel   = 1'b1;
        w_sign_ext  = 1'b1;
      end
      default: begin
        w_shamt = 6'd0;
      end
    endcase
  end

  // Output registers: cleared asynchronously by reset, reloaded from the decode every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jump       <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_sign_ext   <= 1'b0;
      r_reg_dest   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_sel    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_shamt      <= 6'd0;
    end else begin
      r_jump       <= w_jump;
      r_branch     <= w_branch;
      r_mem_to_reg <= w_mem_to_reg;
      r_sign_ext   <= w_sign_ext;
      r_reg_dest   <= w_reg_dest;
      r_mem_write  <= w_mem_write;
      r_alu_sel    <= w_alu_sel;
      r_reg_write  <= w_reg_write;
      r_shamt      <= w_shamt;
    end
  end

  assign jump       = r_jump;
  assign branch     = r_branch;
  assign mem_to_reg = r_mem_to_reg;
  assign sign_ext   = r_sign_ext;
  assign reg_dest   = r_reg_dest;
  assign mem_write  = r_mem_write;
  assign alu_sel    = r_alu_sel;
  assign reg_write  = r_reg_write;
  assign shamt      = r_shamt;

endmodule

// File: tb/tb_z_decoder.sv
// Directed bench for z_decoder. Control bits are packed as
// {jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_sel, reg_write, shamt[5:0]}.
module tb_z_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] ins_in;
  logic        jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_sel, reg_write;
  logic [5:0]  shamt;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [13:0] E_ZERO = {8'b0000_0000, 6'd0};
  localparam logic [13:0] E_BEQ  = {8'b0101_0000, 6'd0};
  localparam logic [13:0] E_RADD = {8'b0000_1001, 6'd0};
  localparam logic [13:0] E_SLL4 = {8'b0000_1001, 6'd4};
  localparam logic [13:0] E_LW   = {8'b0011_0011, 6'd0};
  localparam logic [13:0] E_SW   = {8'b0001_0110, 6'd0};
  localparam logic [13:0] E_J    = {8'b1000_0000, 6'd0};
  localparam logic [13:0] E_ORI  = {8'b0000_0011, 6'd0};
  localparam logic [13:0] E_ADDI = {8'b0001_0011, 6'd0};
  localparam logic [13:0] E_R31  = {8'b0000_1001, 6'd31};

  z_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_in     (ins_in),
    .jump       (jump),
    .branch     (branch),
    .mem_to_reg (mem_to_reg),
    .sign_ext   (sign_ext),
    .reg_dest   (reg_dest),
    .mem_write  (mem_write),
    .alu_sel    (alu_sel),
    .reg_write  (reg_write),
    .shamt      (shamt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] observed();
    return {jump, branch, mem_to_reg, sign_ext, reg_dest, mem_write, alu_sel, reg_write, shamt};
  endfunction

  task automatic chk(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = observed();
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b_%b want %b_%b", tag, obs[13:6], obs[5:0], exp[13:6], exp[5:0]);
  endtask

  // Present a word on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [31:0] word);
    @(negedge clk);
    ins_in = word;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b1;
    ins_in = 32'h8C220004;
    #1 rst_n = 1'b0;
    #1 chk("reset_async", E_ZERO);
    repeat (2) @(posedge clk);
    #1 chk("reset_held_over_edges", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    ins_in = 32'h10221821;
    #1 chk("post_release_no_edge", E_ZERO);
    @(posedge clk);
    #1 chk("beq_first_edge", E_BEQ);

    step(32'h00221820); chk("rtype_add", E_RADD);
    step(32'h00021100); chk("sll_by_4", E_SLL4);
    step(32'h000007C0); chk("rtype_shamt31", E_R31);
    step(32'h8C220004); chk("lw", E_LW);
    step(32'hAC220004); chk("sw", E_SW);
    step(32'h08000010); chk("j", E_J);
    step(32'h3422FFFF); chk("ori", E_ORI);
    step(32'h3022FFFF); chk("andi", E_ORI);
    step(32'h20220005); chk("addi", E_ADDI);
    step(32'h14221821); chk("bne", E_BEQ);
    step(32'hFC000000); chk("undef_op", E_ZERO);
    step(32'hFC0007C0); chk("undef_op_shamt_bits", E_ZERO);
    step(32'h8C2207C4); chk("lw_shamt_bits_ignored", E_LW);

    step(32'h8C220004); chk("lw_before_reset", E_LW);
    @(negedge clk);
    ins_in = 32'hAC220004;
    #1 chk("hold_between_edges", E_LW);
    ins_in = 32'h8C220004;
    #1 rst_n = 1'b0;
    #1 chk("reset_midstream", E_ZERO);
    @(posedge clk);
    #1 chk("reset_midstream_edge", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_no_edge", E_ZERO);
    @(posedge clk);
    #1 chk("lw_after_release", E_LW);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/z_decoder.md
Z_DECODER -- requirements
Module: z_decoder

Interface
- REQ-001: No parameters; all widths fixed.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: ins_in  input  32  instruction word; opcode = ins_in[31:26], shift field = ins_in[10:6].
- REQ-005: jump  output  1  unconditional jump instruction.
- REQ-006: branch  output  1  conditional branch instruction.
- REQ-007: mem_to_reg  output  1  register writeback data comes from memory.
- REQ-008: sign_ext  output  1  16-bit immediate is sign-extended (0 = zero-extend).
- REQ-009: reg_dest  output  1  destination register is rd (1) or rt (0).
- REQ-010: mem_write  output  1  store to data memory.
- REQ-011: alu_sel  output  1  ALU second operand is the immediate (1) or register rt (0).
- REQ-012: reg_write  output  1  register file write enable.
- REQ-013: shamt  output  6  shift amount = {1'b0, ins_in[10:6]}.

Function
- REQ-014: All outputs SHALL be registered; decode of ins_in sampled at rising edge N appears on outputs after edge N, i.e. latency of one cycle.
- REQ-015: Outputs SHALL update every cycle; no enable, no handshake, no internal state beyond the output registers.
- REQ-016: Opcode 000000 (R-type): reg_dest=1, reg_write=1; all other control bits 0; shamt = {1'b0, ins_in[10:6]}.
- REQ-017: Opcode 000010 (J): jump=1; all other control bits 0.
- REQ-018: Opcode 000100 (BEQ) and 000101 (BNE): branch=1, sign_ext=1; all other control bits 0.
- REQ-019: Opcode 001000 (ADDI): reg_write=1, alu_sel=1, sign_ext=1; others 0.
- REQ-020: Opcode 001100 (ANDI) and 001101 (ORI): reg_write=1, alu_sel=1, sign_ext=0; others 0.
- REQ-021: Opcode 100011 (LW): reg_write=1, mem_to_reg=1, alu_sel=1, sign_ext=1; others 0.
- REQ-022: Opcode 101011 (SW): mem_write=1, alu_sel=1, sign_ext=1; others 0.
- REQ-023: Any other opcode SHALL decode as a NOP: all control bits 0, shamt 0.
- REQ-024: shamt SHALL be 0 for every non-R-type opcode.
- REQ-025: At most one of jump, branch, mem_write, reg_write-with-mem_to_reg groups is active; jump and branch are never both 1.
- REQ-026: X/Z on ins_in is not required to be handled; decode is a pure function of the 6-bit opcode and ins_in[10:6].

Reset
- REQ-027: While rst_n=0, all outputs SHALL be 0 immediately (asynchronous), independent of clk.
- REQ-028: After rst_n deasserts, the first rising edge SHALL load the decode of the current ins_in.
- REQ-029: Reset asserted mid-stream SHALL clear outputs at once; no pending decode survives reset.

Verification
- REQ-030: ins_in=0x10221821 (BEQ), one edge -> branch=1, sign_ext=1, all others 0, shamt=0.
- REQ-031: ins_in=0x00221820 (R-type add) -> reg_dest=1, reg_write=1, others 0, shamt=0; then 0x00021100 (sll by 4) -> shamt=6'd4, reg_dest=1, reg_write=1.
- REQ-032: ins_in=0x8C220004 (LW) -> reg_write=1, mem_to_reg=1, alu_sel=1, sign_ext=1; then 0xAC220004 (SW) -> mem_write=1, alu_sel=1, sign_ext=1, reg_write=0.
- REQ-033: ins_in=0x08000010 (J) -> jump=1 only; ins_in=0x3422FFFF (ORI) -> reg_write=1, alu_sel=1, sign_ext=0.
- REQ-034: ins_in=0xFC000000 (undefined opcode) -> all outputs 0.
- REQ-035: Apply LW, assert rst_n=0 between clock edges -> all outputs 0 before the next edge; release and clock once -> LW decode reappears; outputs never change other than at edges or on reset assertion.
